gen_mac: RTL

- Parametrised, pipelined multiply-accumulate unit. It is the registered successor to the team's combinational generic multiplier.
- Multiplies two operands in signed or unsigned mode, selected per beat.
- Either loads or accumulates each product into a wide accumulator.
- Streams results out over a valid/ready handshake with full backpressure.
- Sits in the datapath between operand sources (gradient/perturbation terms) and downstream update logic.

---
 rtl/gen_mac_pkg.sv | 18 +
 rtl/gen_mac_if.sv | 33 +++
 rtl/gen_mac_mult_pipe.sv | 63 ++++++
 rtl/gen_mac.sv | 96 +++++++++
 4 files changed

// File: rtl/gen_mac_pkg.sv
// -----------------------------------------------------------------------------
// gen_mac_pkg : shared constants and the mode-dependent extension helper
// Revision 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package gen_mac_pkg;

   localparam int MAC_LATENCY = 3;

   // Fill bit used when widening a value: the MSB in signed mode, zero otherwise.
   function automatic logic ext_bit(input logic signed_en, input logic msb);
      return signed_en & msb;
   endfunction

endpackage

`default_nettype wire

// File: rtl/gen_mac_if.sv
// -----------------------------------------------------------------------------
// gen_mac_if : operand/result valid-ready bundle for gen_mac
// Revision 1.0
// -----------------------------------------------------------------------------
`default_nettype none

interface gen_mac_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ACC_WIDTH  = 40
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] a;
   logic [DATA_WIDTH-1:0] b;
   logic                  signed_en;
   logic                  first;
   logic                  out_valid;
   logic                  out_ready;
   logic [ACC_WIDTH-1:0]  p;
   logic                  overflow;

   modport master (
      output in_valid, a, b, signed_en, first, out_ready,
      input  in_ready, out_valid, p, overflow
   );

   modport slave (
      input  in_valid, a, b, signed_en, first, out_ready,
      output in_ready, out_valid, p, overflow
   );
endinterface

`default_nettype wire

// File: rtl/gen_mac_mult_pipe.sv
// -----------------------------------------------------------------------------
// gen_mult_pipe : two-stage registered signed/unsigned multiplier with enable
// Revision 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module gen_mult_pipe #(
   parameter int DATA_WIDTH = 16
) (
   input  wire logic                    clk,
   input  wire logic                    rst,
   input  wire logic                    en,
   input  wire logic                    in_valid,
   input  wire logic [DATA_WIDTH-1:0]   a,
   input  wire logic [DATA_WIDTH-1:0]   b,
   input  wire logic                    signed_en,
   input  wire logic                    first,
   output logic                         out_valid,
   output logic [2*DATA_WIDTH-1:0]      product,
   output logic                         out_signed,
   output logic                         out_first
);
   import gen_mac_pkg::*;

   logic                    r_v1;
   logic                    r_s1;
   logic                    r_f1;
   logic [DATA_WIDTH-1:0]   r_a;
   logic [DATA_WIDTH-1:0]   r_b;
   logic [2*DATA_WIDTH-1:0] w_a_ext;
   logic [2*DATA_WIDTH-1:0] w_b_ext;

   // Widening straight to the product width keeps the multiply exact modulo 2^(2W).
   assign w_a_ext = {{DATA_WIDTH{ext_bit(r_s1, r_a[DATA_WIDTH-1])}}, r_a};
   assign w_b_ext = {{DATA_WIDTH{ext_bit(r_s1, r_b[DATA_WIDTH-1])}}, r_b};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_v1       <= 1'b0;
         r_s1       <= 1'b0;
         r_f1       <= 1'b0;
         r_a        <= '0;
         r_b        <= '0;
         out_valid  <= 1'b0;
         product    <= '0;
         out_signed <= 1'b0;
         out_first  <= 1'b0;
      end else if (en) begin
         r_v1       <= in_valid;
         r_s1       <= signed_en;
         r_f1       <= first;
         r_a        <= a;
         r_b        <= b;
         out_valid  <= r_v1;
         product    <= w_a_ext * w_b_ext;
         out_signed <= r_s1;
         out_first  <= r_f1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/gen_mac.sv
// -----------------------------------------------------------------------------
// gen_mac : pipelined multiply-accumulate with valid/ready backpressure
// Revision 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module gen_mac #(
   parameter int DATA_WIDTH = 16,
   parameter int ACC_WIDTH  = 40
) (
   input  wire logic clk,
   input  wire logic rst,
   gen_mac_if.slave  bus
);
   import gen_mac_pkg::*;

   localparam int PROD_WIDTH = 2 * DATA_WIDTH;

   generate
      if (ACC_WIDTH < PROD_WIDTH) begin : g_width_check
         $fatal(1, "gen_mac: ACC_WIDTH must be >= 2*DATA_WIDTH");
      end
   endgenerate

   logic                  w_advance;
   logic                  w_v2;
   logic                  w_s2;
   logic                  w_f2;
   logic [PROD_WIDTH-1:0] w_prod;
   logic [ACC_WIDTH-1:0]  w_prod_ext;
   logic [ACC_WIDTH:0]    w_sum;
   logic                  w_ovf;
   logic [ACC_WIDTH-1:0]  r_acc;
   logic                  r_ovf;
   logic                  r_out_valid;

   assign w_advance    = !r_out_valid | bus.out_ready;
   assign bus.in_ready = w_advance & !rst;

   gen_mult_pipe #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_mult (
      .clk        (clk),
      .rst        (rst),
      .en         (w_advance),
      .in_valid   (bus.in_valid),
      .a          (bus.a),
      .b          (bus.b),
      .signed_en  (bus.signed_en),
      .first      (bus.first),
      .out_valid  (w_v2),
      .product    (w_prod),
      .out_signed (w_s2),
      .out_first  (w_f2)
   );

   generate
      if (ACC_WIDTH > PROD_WIDTH) begin : g_ext_wide
         assign w_prod_ext = {{(ACC_WIDTH-PROD_WIDTH){ext_bit(w_s2, w_prod[PROD_WIDTH-1])}}, w_prod};
      end else begin : g_ext_exact
         assign w_prod_ext = w_prod;
      end
   endgenerate

   // One extra bit captures the unsigned carry; signed overflow uses the sign rule.
   assign w_sum = {1'b0, r_acc} + {1'b0, w_prod_ext};
   assign w_ovf = w_s2 ? ((r_acc[ACC_WIDTH-1] == w_prod_ext[ACC_WIDTH-1]) &&
                          (w_sum[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]))
                       : w_sum[ACC_WIDTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc       <= '0;
         r_ovf       <= 1'b0;
         r_out_valid <= 1'b0;
      end else if (w_advance) begin
         r_out_valid <= w_v2;
         if (w_v2) begin
            if (w_f2) begin
               r_acc <= w_prod_ext;
               r_ovf <= 1'b0;
            end else begin
               r_acc <= w_sum[ACC_WIDTH-1:0];
               r_ovf <= w_ovf;
            end
         end
      end
   end

   assign bus.out_valid = r_out_valid;
   assign bus.p         = r_acc;
   assign bus.overflow  = r_ovf;

endmodule

`default_nettype wire
